csr_hpm_unit: RTL and testbench

CSR_HPM_UNIT -- requirements
Module: csr_hpm_unit

---
 rtl/csr_hpm_unit.sv | 156 +++++++++++++++
 tb/tb_csr_hpm_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_hpm_unit.sv
// Machine/user hardware performance counters: mcycle, minstret, mhpmcounterN.
// Decodes the counter CSRs, their user shadows, event selectors and enables.
module csr_hpm_unit #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            priv_mode,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_ren,
    input  logic                  csr_wen,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit,
    output logic                  csr_illegal,
    input  logic                  instret,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [NUM_HPM-1:0]    ovf_o
);

    localparam int          NCNT     = 3 + NUM_HPM;
    localparam int          HW       = CNT_WIDTH - 32;
    localparam logic [63:0] MASK64   = ((64'd1 << NCNT) - 64'd1) & ~64'd2;
    localparam logic [31:0] CNT_MASK = MASK64[31:0];

    logic [CNT_WIDTH-1:0] cnt_q [32];
    logic [CNT_WIDTH-1:0] cnt_d [32];
    logic [7:0]           evt_q [32];
    logic [7:0]           evt_d [32];
    logic [31:0]          inh_q, inh_d;
    logic [31:0]          en_q, en_d;
    logic [NUM_HPM-1:0]   ovf_q, ovf_d;
    logic [31:0]          inc_en;
    logic [31:0]          wrap;
    logic [255:0]         ev_pad;

    logic [4:0] idx;
    logic       idx_ok, is_hi, is_cnt_m, is_cnt_u, is_evt, is_inh, is_en;
    logic       user, wr_ok;

    assign idx      = csr_addr[4:0];
    assign is_hi    = csr_addr[7];
    assign idx_ok   = (idx != 5'd1) && (int'(idx) < NCNT);
    assign is_cnt_m = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00) && idx_ok;
    assign is_cnt_u = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00) && idx_ok;
    assign is_evt   = (csr_addr[11:5] == 7'h19) && (idx >= 5'd3) && (int'(idx) < NCNT);
    assign is_inh   = (csr_addr == 12'h320);
    assign is_en    = (csr_addr == 12'h306);
    assign user     = (priv_mode == 2'b00);

    assign csr_hit  = is_cnt_m || is_cnt_u || is_evt || is_inh || is_en;

    // Every non-shadow register is machine-only; shadows are read-only.
    assign csr_illegal = csr_hit && (csr_ren || csr_wen) &&
                         ((csr_wen && is_cnt_u) ||
                          (user && !is_cnt_u) ||
                          (user && csr_ren && is_cnt_u && !en_q[idx]));

    assign wr_ok = csr_wen && csr_hit && !csr_illegal;

    // Bit 0 is a dummy so that selector value k lands on event_i[k-1].
    always_comb begin
        ev_pad = '0;
        ev_pad[NUM_EVENTS:0] = {event_i, 1'b0};
    end

    always_comb begin
        inc_en = '0;
        for (int c = 0; c < 32; c++) begin
            if (c == 0)
                inc_en[c] = 1'b1;
            else if (c == 2)
                inc_en[c] = instret;
            else if (c >= 3 && c < NCNT)
                inc_en[c] = ev_pad[evt_q[c]];
            inc_en[c] = inc_en[c] & ~inh_q[c];
        end
    end

    always_comb begin
        inh_d = inh_q;
        en_d  = en_q;
        wrap  = '0;
        if (wr_ok && is_inh)
            inh_d = csr_wdata & CNT_MASK;
        if (wr_ok && is_en)
            en_d = csr_wdata & CNT_MASK;
        for (int c = 0; c < 32; c++) begin
            cnt_d[c] = cnt_q[c];
            evt_d[c] = evt_q[c];
            if (c == 1 || c >= NCNT) begin
                cnt_d[c] = '0;
                evt_d[c] = '0;
            end else begin
                if (wr_ok && is_cnt_m && int'(idx) == c) begin
                    if (is_hi)
                        cnt_d[c][CNT_WIDTH-1:32] = csr_wdata[HW-1:0];
                    else
                        cnt_d[c][31:0] = csr_wdata;
                end else if (inc_en[c]) begin
                    cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
                    wrap[c]  = &cnt_q[c];
                end
                if (c < 3)
                    evt_d[c] = '0;
                else if (wr_ok && is_evt && int'(idx) == c)
                    evt_d[c] = csr_wdata[7:0];
            end
        end
    end

    always_comb begin
        ovf_d = '0;
        for (int i = 0; i < NUM_HPM; i++)
            ovf_d[i] = wrap[3+i];
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_hit && !csr_illegal) begin
            if (is_cnt_m || is_cnt_u)
                csr_rdata = is_hi ? 32'(cnt_q[idx] >> 32) : cnt_q[idx][31:0];
            else if (is_evt)
                csr_rdata = {24'd0, evt_q[idx]};
            else if (is_inh)
                csr_rdata = inh_q;
            else if (is_en)
                csr_rdata = en_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 32; c++) begin
                cnt_q[c] <= '0;
                evt_q[c] <= '0;
            end
            inh_q <= '0;
            en_q  <= '0;
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < 32; c++) begin
                cnt_q[c] <= cnt_d[c];
                evt_q[c] <= evt_d[c];
            end
            inh_q <= inh_d;
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Bench for csr_hpm_unit: expected read responses are queued when an access
// is driven and compared when the outputs settle.
module tb_csr_hpm_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  priv_mode;
    logic [11:0] csr_addr;
    logic        csr_ren, csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit, csr_illegal;
    logic        instret;
    logic [7:0]  event_i;
    logic [3:0]  ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        hit;
        logic        ill;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    csr_hpm_unit dut (
        .clock      (clock),
        .reset      (reset),
        .priv_mode  (priv_mode),
        .csr_addr   (csr_addr),
        .csr_ren    (csr_ren),
        .csr_wen    (csr_wen),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_hit    (csr_hit),
        .csr_illegal(csr_illegal),
        .instret    (instret),
        .event_i    (event_i),
        .ovf_o      (ovf_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_hit"}, 64'(csr_hit), 64'(e.hit));
        check({e.tag, "_ill"}, 64'(csr_illegal), 64'(e.ill));
        check({e.tag, "_data"}, 64'(csr_rdata), 64'(e.data));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [11:0] a,
                          input logic [31:0] d, input logic ill);
        sb.push_back('{tag, 1'b1, ill, 32'd0});
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        @(negedge clock);
        sb_cmp();
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic hit,
                      input logic ill, input logic [31:0] d);
        sb.push_back('{tag, hit, ill, d});
        csr_addr = a;
        csr_ren  = 1'b1;
        @(negedge clock);
        sb_cmp();
        tick();
        csr_ren  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        priv_mode = 2'b11;
        csr_addr  = '0;
        csr_ren   = 1'b0;
        csr_wen   = 1'b0;
        csr_wdata = '0;
        instret   = 1'b0;
        event_i   = '0;
        repeat (3) tick();
        check("rst_ovf", 64'(ovf_o), 64'd0);
        rd("rst_mcycle", 12'hB00, 1'b1, 1'b0, 32'd0);

        reset = 1'b0;
        repeat (10) tick();
        rd("cyc10", 12'hB00, 1'b1, 1'b0, 32'd10);
        rd("cyc10h", 12'hB80, 1'b1, 1'b0, 32'd0);

        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'd0);
        tick();
        rd("carry_lo", 12'hB00, 1'b1, 1'b0, 32'd0);
        rd("carry_hi", 12'hB80, 1'b1, 1'b0, 32'd1);

        instret = 1'b1;
        repeat (3) tick();
        instret = 1'b0;
        rd("instret3", 12'hB02, 1'b1, 1'b0, 32'd3);
        sb.push_back('{"rw_same", 1'b1, 1'b0, 32'd3});
        csr_addr  = 12'hB02;
        csr_wdata = 32'h1234;
        csr_ren   = 1'b1;
        csr_wen   = 1'b1;
        @(negedge clock);
        sb_cmp();
        tick();
        csr_ren = 1'b0;
        csr_wen = 1'b0;
        rd("rd_after_wr", 12'hB02, 1'b1, 1'b0, 32'h1234);

        wr(12'h323, 32'd2);
        rd("evt3", 12'h323, 1'b1, 1'b0, 32'd2);
        for (int k = 0; k < 8; k++) begin
            event_i = (k < 5) ? 8'h02 : 8'h01;
            tick();
            event_i = '0;
        end
        rd("hpm3_5", 12'hB03, 1'b1, 1'b0, 32'd5);
        wr(12'h320, 32'd8);
        for (int k = 0; k < 4; k++) begin
            event_i = 8'h02;
            tick();
            event_i = '0;
        end
        rd("hpm3_inh", 12'hB03, 1'b1, 1'b0, 32'd5);
        rd("inh_rd", 12'h320, 1'b1, 1'b0, 32'd8);
        wr(12'h320, 32'hFFFF_FFFF);
        rd("inh_mask", 12'h320, 1'b1, 1'b0, 32'h7D);
        wr(12'h306, 32'hFFFF_FFFF);
        rd("en_mask", 12'h306, 1'b1, 1'b0, 32'h7D);
        wr(12'h306, 32'd0);
        wr(12'h320, 32'd0);

        wr(12'h325, 32'd9);
        wr(12'h326, 32'h1FF);
        rd("evt5", 12'h325, 1'b1, 1'b0, 32'd9);
        rd("evt6_8b", 12'h326, 1'b1, 1'b0, 32'hFF);
        event_i = 8'hFF;
        repeat (3) tick();
        event_i = '0;
        rd("hpm5_sel9", 12'hB05, 1'b1, 1'b0, 32'd0);
        rd("hpm4_sel0", 12'hB04, 1'b1, 1'b0, 32'd0);
        rd("hpm3_8", 12'hB03, 1'b1, 1'b0, 32'd8);

        wr(12'h324, 32'd3);
        wr(12'hB04, 32'hFFFF_FFFF);
        wr(12'hB84, 32'hFFFF_FFFF);
        check("ovf_wr", 64'(ovf_o), 64'd0);
        event_i = 8'h04;
        tick();
        event_i = '0;
        @(negedge clock);
        check("ovf_pulse", 64'(ovf_o), 64'h2);
        tick();
        @(negedge clock);
        check("ovf_1cyc", 64'(ovf_o), 64'd0);
        tick();
        rd("wrap_lo", 12'hB04, 1'b1, 1'b0, 32'd0);
        rd("wrap_hi", 12'hB84, 1'b1, 1'b0, 32'd0);

        wr(12'h320, 32'd1);
        wr(12'hB00, 32'hABCD);
        wr(12'hB80, 32'h12);
        priv_mode = 2'b00;
        rd("u_noen", 12'hC00, 1'b1, 1'b1, 32'd0);
        priv_mode = 2'b11;
        wr(12'h306, 32'd1);
        priv_mode = 2'b00;
        rd("u_cyc", 12'hC00, 1'b1, 1'b0, 32'hABCD);
        rd("u_cych", 12'hC80, 1'b1, 1'b0, 32'h12);
        rd("u_ret_noen", 12'hC02, 1'b1, 1'b1, 32'd0);
        rd("u_mach", 12'hB00, 1'b1, 1'b1, 32'd0);
        rd("u_c01", 12'hC01, 1'b0, 1'b0, 32'd0);
        wr_chk("u_wr_shadow", 12'hC00, 32'd5, 1'b1);
        wr_chk("u_wr_mach", 12'hB00, 32'd7, 1'b1);
        priv_mode = 2'b11;
        wr_chk("m_wr_shadow", 12'hC00, 32'd9, 1'b1);
        rd("cyc_kept", 12'hB00, 1'b1, 1'b0, 32'hABCD);

        wr(12'h320, 32'd0);
        instret = 1'b1;
        repeat (2) tick();
        reset     = 1'b1;
        csr_addr  = 12'hB02;
        csr_wdata = 32'h55;
        csr_wen   = 1'b1;
        tick();
        reset   = 1'b0;
        csr_wen = 1'b0;
        instret = 1'b0;
        rd("rst_wr_ret", 12'hB02, 1'b1, 1'b0, 32'd0);
        rd("rst_evt", 12'h323, 1'b1, 1'b0, 32'd0);
        rd("rst_resume", 12'hB00, 1'b1, 1'b0, 32'd2);
        rd("rst_en", 12'h306, 1'b1, 1'b0, 32'd0);
        check("rst_ovf2", 64'(ovf_o), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
